// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory-side responder.
//   mem_state_t : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   NUM_LANES   : byte lanes per 32-bit word
//   WS_W        : width of the wait-state counter
//   merge_lanes : byte-strobed merge of new write data over an old word
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int NUM_LANES = 4;
    localparam int WS_W      = 4;

    // Lanes with the strobe set take the new byte, others keep the old byte.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0]          old_word,
        input logic [31:0]          new_word,
        input logic [NUM_LANES-1:0] strobe
    );
        logic [31:0] merged;
        merged = old_word;
        for (int li = 0; li < NUM_LANES; li++) begin
            if (strobe[li]) begin
                merged[8*li +: 8] = new_word[8*li +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// DEPTH_WORDS x 32-bit word storage with per-byte-lane write enables.
//   clk     : clock, writes on rising edge
//   i_we    : per-lane write enable (bit i covers i_wdata[8i+7:8i])
//   i_addr  : word index (shared by read and write)
//   i_wdata : write data
//   o_rdata : combinational read of mem[i_addr]; the responder registers it
// INIT_FILE is accepted for interface compatibility; contents start undefined.
// ---------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic [NUM_LANES-1:0] i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int li = 0; li < NUM_LANES; li++) begin
            if (i_we[li]) begin
                r_mem[i_addr][8*li +: 8] <= i_wdata[8*li +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the multicycle core's unified instr/data port.
// One word read or byte-strobed write per request, a fixed WAIT_STATES
// latency, then a one-cycle response pulse with read data and an error flag.
//   clk        : clock
//   reset      : synchronous, active-low reset
//   req_valid  : request present
//   req_ready  : high only in IDLE
//   req_we     : 1 = write, 0 = read
//   req_addr   : byte address
//   req_wdata  : write data
//   req_wstrb  : byte-lane enables
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : read data (post-write word for writes), held between responses
//   rsp_err    : misaligned / out-of-range access, valid with rsp_valid
// ---------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t     r_state;
    mem_state_t     w_state_next;
    logic [WS_W-1:0] r_cnt;
    logic [WS_W-1:0] w_cnt_next;

    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [NUM_LANES-1:0] r_wstrb;
    logic [31:0]          r_rdata;
    logic                 r_err;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_sel_we;
    logic [31:0]          w_sel_addr;
    logic [31:0]          w_sel_wdata;
    logic [NUM_LANES-1:0] w_sel_wstrb;
    logic [31:0]          w_off;
    logic [31:0]          w_word;
    logic                 w_err;
    logic                 w_enter_resp;
    logic [NUM_LANES-1:0] w_lane_we;
    logic [31:0]          w_mem_rdata;
    logic [31:0]          w_merged;
    logic [31:0]          w_rsp_data;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && req_valid;

    // With zero wait states the RAM access happens on the accept edge itself,
    // so the decode must look at the live request rather than the capture regs.
    assign w_sel_we    = w_idle ? req_we    : r_we;
    assign w_sel_addr  = w_idle ? req_addr  : r_addr;
    assign w_sel_wdata = w_idle ? req_wdata : r_wdata;
    assign w_sel_wstrb = w_idle ? req_wstrb : r_wstrb;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign w_off  = w_sel_addr - BASE_ADDR;
    assign w_word = w_off >> 2;
    assign w_err  = (w_sel_addr[1:0] != 2'b00) || (w_word >= 32'(DEPTH_WORDS));

    // Reset at the access edge suppresses the write along with the response.
    assign w_enter_resp = reset &&
                          ((w_accept && (WAIT_STATES == 0)) ||
                           ((r_state == WAIT) && (r_cnt == '0)));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign w_lane_we[gi] = w_enter_resp && w_sel_we && !w_err && w_sel_wstrb[gi];
        end
    endgenerate

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .AW          (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_lane_we),
        .i_addr  (w_word[AW-1:0]),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Writes report the word as it will read after the update.
    assign w_merged   = merge_lanes(w_mem_rdata, w_sel_wdata, w_sel_wstrb);
    assign w_rsp_data = w_err    ? 32'h0    :
                        w_sel_we ? w_merged : w_mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = WS_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= w_rsp_data;
            r_err   <= w_err;
        end else if (r_state == RESP) begin
            r_err   <= 1'b0;
        end
    end

    assign req_ready = w_idle;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
